// File: rtl/gate_truth_table_sequencer.sv
// Stimulus-and-check sequencer for a 2-input gate: walks (a,b) through 00,01,10,11,
// samples y on the last hold cycle of each pattern and tallies mismatches against a golden function.
module gate_truth_table_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       expected,
  output logic       mismatch,
  output logic [2:0] err_count,
  output logic       busy,
  output logic       done,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        pattern_q;
  logic [HOLD_W-1:0] hold_q;
  logic [1:0]        sel_q;
  logic              launch;
  logic              sample_edge;
  logic              last_pattern;
  logic              fail;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (sample_edge && last_pattern) state_d = DONE;
      DONE:    if (start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch       = 1'b0;
    sample_edge  = 1'b0;
    last_pattern = (pattern_q == 2'd3);
    expected     = 1'b0;
    unique case (state_q)
      IDLE, DONE: launch      = start;
      DRIVE:      sample_edge = (hold_q == HOLD_LAST);
      default:    launch      = 1'b0;
    endcase
    unique case (sel_q)
      2'd0:    expected = ~(a & b);
      2'd1:    expected = ~(a | b);
      2'd2:    expected = a & b;
      default: expected = a | b;
    endcase
    fail = sample_edge && (y != expected);
    pass = done && (err_count == 3'd0);
  end

  // Stimulus, hold timing and result bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= 1'b0;
      b         <= 1'b0;
      pattern_q <= 2'd0;
      hold_q    <= '0;
      sel_q     <= 2'd0;
      mismatch  <= 1'b0;
      err_count <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mismatch <= fail;
      if (launch) begin
        sel_q     <= sel;
        err_count <= 3'd0;
        done      <= 1'b0;
        busy      <= 1'b1;
        pattern_q <= 2'd0;
        hold_q    <= '0;
        a         <= 1'b0;
        b         <= 1'b0;
      end else if (state_q == DRIVE) begin
        if (fail && (err_count != 3'd4)) err_count <= err_count + 3'd1;
        if (!sample_edge) begin
          hold_q <= hold_q + 1'b1;
        end else if (!last_pattern) begin
          pattern_q <= pattern_q + 2'd1;
          hold_q    <= '0;
          {a, b}    <= pattern_q + 2'd1;
        end else begin
          pattern_q <= 2'd0;
          hold_q    <= '0;
          a         <= 1'b0;
          b         <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Bench for gate_truth_table_sequencer: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance, each checked
// every cycle against a cycle-count based model of the sweep, plus directed literal checkpoints.
module tb_gate_truth_table_sequencer;

  logic       clk = 1'b0;
  logic [1:0] rst_v = 2'b11;
  logic [1:0] start_v = 2'b00;
  logic [1:0] sel_v [2];
  int         gfn [2];

  logic [1:0] a_w, b_w, exp_w, mis_w, busy_w, done_w, pass_w, y_w;
  logic [2:0] err_w [2];

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Model state: a sweep is tracked purely by edges elapsed since its start edge.
  int hc [2];
  bit run_m  [2];
  int j_m    [2];
  int sel_m  [2];
  int err_m  [2];
  bit done_m [2];
  bit mis_m  [2];

  always #5 clk = ~clk;

  function automatic logic gold(input int s, input logic ga, input logic gb);
    case (s)
      0:       return !(ga && gb);
      1:       return !(ga || gb);
      2:       return ga && gb;
      default: return ga || gb;
    endcase
  endfunction

  // Gate under test: 0..3 behave like the golden functions, 4 is stuck-at-1, 5 is XOR.
  function automatic logic gut(input int f, input logic ga, input logic gb);
    if (f < 4)  return gold(f, ga, gb);
    if (f == 4) return 1'b1;
    return ga ^ gb;
  endfunction

  always_comb y_w[0] = gut(gfn[0], a_w[0], b_w[0]);
  always_comb y_w[1] = gut(gfn[1], a_w[1], b_w[1]);

  gate_truth_table_sequencer #(.HOLD_CYCLES(4), .HOLD_W(8)) dut4 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .sel(sel_v[0]), .y(y_w[0]),
    .a(a_w[0]), .b(b_w[0]), .expected(exp_w[0]), .mismatch(mis_w[0]),
    .err_count(err_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0])
  );

  gate_truth_table_sequencer #(.HOLD_CYCLES(1), .HOLD_W(2)) dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .sel(sel_v[1]), .y(y_w[1]),
    .a(a_w[1]), .b(b_w[1]), .expected(exp_w[1]), .mismatch(mis_w[1]),
    .err_count(err_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_step(input int i);
    logic [1:0] p;
    if (rst_v[i]) begin
      run_m[i] = 0; j_m[i] = 0; sel_m[i] = 0; err_m[i] = 0; done_m[i] = 0; mis_m[i] = 0;
    end else begin
      mis_m[i] = 0;
      if (run_m[i]) begin
        j_m[i]++;
        if (j_m[i] % hc[i] == 0) begin
          p = 2'(j_m[i] / hc[i] - 1);
          if (gut(gfn[i], p[1], p[0]) != gold(sel_m[i], p[1], p[0])) begin
            err_m[i]++;
            mis_m[i] = 1;
          end
          if (j_m[i] == 4 * hc[i]) begin
            run_m[i]  = 0;
            done_m[i] = 1;
          end
        end
      end else if (start_v[i]) begin
        run_m[i] = 1; j_m[i] = 0; sel_m[i] = int'(sel_v[i]); err_m[i] = 0; done_m[i] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Per-cycle compare of all outputs, packed as {a,b,expected,mismatch,err_count,busy,done,pass}.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] pm;
        logic [9:0] act, exp;
        pm  = run_m[i] ? 2'(j_m[i] / hc[i]) : 2'd0;
        exp = {pm[1], pm[0], gold(sel_m[i], pm[1], pm[0]), mis_m[i], 3'(err_m[i]),
               run_m[i], done_m[i], done_m[i] && (err_m[i] == 0)};
        act = {a_w[i], b_w[i], exp_w[i], mis_w[i], err_w[i], busy_w[i], done_w[i], pass_w[i]};
        check(i == 0 ? "outs_h4" : "outs_h1", 32'(act), 32'(exp));
      end
    end
  end

  task automatic pulse_start0();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
  endtask

  initial begin
    int done_cnt;
    hc[0] = 4; hc[1] = 1;
    sel_v[0] = 2'd0; sel_v[1] = 2'd0;
    gfn[0] = 0; gfn[1] = 0;
    tick();
    armed = 1'b1;
    tick();
    rst_v = 2'b00;
    tick();
    check("reset_err", 32'(err_w[0]), 32'd0);
    check("reset_busy_done", 32'({busy_w[0], done_w[0], pass_w[0]}), 32'd0);

    // Correct NAND gate: clean sweep with patterns every 4 cycles.
    pulse_start0();
    check("nand_ab_00", 32'({a_w[0], b_w[0]}), 32'b00);
    check("nand_busy", 32'(busy_w[0]), 32'd1);
    repeat (4) tick();
    check("nand_ab_01", 32'({a_w[0], b_w[0]}), 32'b01);
    repeat (4) tick();
    check("nand_ab_10", 32'({a_w[0], b_w[0]}), 32'b10);
    repeat (7) tick();
    check("nand_not_done_e15", 32'(done_w[0]), 32'd0);
    tick();
    check("nand_done_e16", 32'({done_w[0], pass_w[0], busy_w[0], err_w[0]}), 32'b110_000);

    // Stuck-at-1 output: only pattern 11 fails.
    gfn[0] = 4;
    pulse_start0();
    repeat (15) tick();
    check("stuck1_no_mis_yet", 32'(mis_w[0]), 32'd0);
    tick();
    check("stuck1_mis_err", 32'({mis_w[0], err_w[0], pass_w[0]}), 32'b1_001_0);
    tick();
    check("stuck1_mis_gone", 32'(mis_w[0]), 32'd0);

    // AND gate against NAND golden: every pattern fails.
    gfn[0] = 2;
    pulse_start0();
    repeat (16) tick();
    check("and_err4", 32'({err_w[0], done_w[0]}), 32'b100_1);

    // NOR golden, sel moved to OR and start re-pulsed mid-sweep: both ignored.
    gfn[0] = 1; sel_v[0] = 2'd1;
    pulse_start0();
    repeat (5) tick();
    sel_v[0] = 2'd3;
    pulse_start0();
    repeat (10) tick();
    check("nor_done_e16", 32'({done_w[0], err_w[0], pass_w[0]}), 32'b1_000_1);

    // Reset during pattern 10 aborts the sweep.
    gfn[0] = 0; sel_v[0] = 2'd0;
    pulse_start0();
    repeat (9) tick();
    check("abort_ab_10", 32'({a_w[0], b_w[0]}), 32'b10);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    check("abort_state", 32'({a_w[0], b_w[0], busy_w[0], err_w[0], done_w[0]}), 32'd0);
    pulse_start0();
    repeat (16) tick();
    check("after_abort_pass", 32'(pass_w[0]), 32'd1);

    // HOLD_CYCLES=1 with start held: a done pulse every 5th cycle, gate changing freely.
    start_v[1] = 1'b1;
    tick();
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (done_w[1] === 1'b1) done_cnt++;
      gfn[1] = int'($urandom_range(0, 5));
      tick();
    end
    check("h1_done_pulses", 32'(done_cnt), 32'd5);
    start_v[1] = 1'b0;

    // Random traffic on both instances.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        rst_v[i]   = ($urandom_range(0, 149) == 0);
        start_v[i] = ($urandom_range(0, 3) == 0);
        sel_v[i]   = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) gfn[i] = int'($urandom_range(0, 5));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sequencer.md
Name:
gate_truth_table_sequencer

Overview:
- Sequential stimulus-and-check stage wrapped around a 2-input combinational gate under test, e.g. the De Morgan second-law circuit with ports a, b, y.
- Upstream role: drives a, b through all four input combinations, holding each for a fixed number of cycles.
- Downstream role: samples the gate's y and compares it against a golden function.
- Reports a mismatch pulse per failing pattern, an error count and pass/done status, so the lab boards self-check without a waveform viewer.

Parameters:
- HOLD_CYCLES, default 4: clock cycles each input pattern is held; minimum 1.
- HOLD_W, default 8: width of the internal hold counter; must satisfy 2^HOLD_W >= HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to run one full sweep.
- sel  input  2  golden function select: 0 = NAND ~(a&b), equivalently ~a|~b; 1 = NOR ~(a|b), equivalently ~a&~b; 2 = AND; 3 = OR.
- y  input  1  output of the gate under test.
- a  output  1  stimulus bit A to the gate under test.
- b  output  1  stimulus bit B to the gate under test.
- expected  output  1  golden value for the current a, b and latched sel.
- mismatch  output  1  one-cycle pulse flagging that the last sampled pattern failed.
- err_count  output  3  number of failing patterns in the current or last sweep, range 0..4.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high once a sweep has completed.
- pass  output  1  equals done AND (err_count == 0).

Behaviour:
- Reset, synchronous on rst=1 at a rising edge:
  - State goes to IDLE.
  - a=0, b=0, mismatch=0, err_count=0, busy=0, done=0, pass=0.
  - Pattern counter and hold counter go to 0; latched sel goes to 0.
  - rst has priority over every other input, including in mid-sweep.
- State machine, states IDLE, DRIVE, DONE:
  - IDLE -> DRIVE when start=1 at an edge. That edge latches sel into sel_q, clears err_count and done, sets pattern=0, hold=0 and busy=1.
  - DRIVE, at each edge:
    - If hold < HOLD_CYCLES-1: hold increments.
    - If hold == HOLD_CYCLES-1 (sample edge): y is compared with expected. On a difference, mismatch=1 for the following cycle and err_count increments.
    - After the sample edge, if pattern < 3: pattern increments and hold returns to 0.
    - After the sample edge, if pattern == 3: go to DONE with busy=0 and done=1.
  - DONE: done and pass stay high and err_count holds its value. start=1 re-enters DRIVE with the same actions as IDLE -> DRIVE.
- Pattern order, pattern[1]=a and pattern[0]=b: (a,b) = 00, 01, 10, 11. b toggles every HOLD_CYCLES cycles; a toggles every 2*HOLD_CYCLES cycles.
- a and b are registered, driven directly from the pattern counter in DRIVE, and are 0 in IDLE and DONE.
- expected is combinational from a, b and sel_q.
- mismatch is registered: it is high only in the cycle after a failing sample edge, otherwise 0.
- Latency:
  - a,b = 00 appear in the cycle after the start edge.
  - The sweep lasts exactly 4*HOLD_CYCLES cycles.
  - done rises 4*HOLD_CYCLES edges after the start edge.
- Sampling only on the last hold cycle gives the gate under test HOLD_CYCLES-1 cycles of settling.
- Boundary conditions:
  - start while busy is ignored.
  - sel changes while busy are ignored; only sel_q is used.
  - start held high continuously gives back-to-back sweeps, with done high for one cycle between them.
  - err_count maxes at 4, so it never overflows 3 bits.
  - With HOLD_CYCLES=1, every edge in DRIVE is a sample edge.
  - Reset mid-sweep aborts the sweep and produces the reset values on the next edge.

Test Plan:
- HOLD_CYCLES=4, sel=0, correct NAND model (y = ~a|~b), start pulse at edge 0 -> a,b = 00/01/10/11 each for 4 cycles; done=1 after edge 16; err_count=0; pass=1; mismatch never high.
- sel=0, y stuck at 1 -> a single mismatch pulse in the cycle after the pattern-11 sample edge; err_count=1; pass=0.
- sel=0, y = a&b -> mismatch pulses after all four sample edges; err_count=4.
- sel=1 (NOR) with a NOR model; then sel switched to 3 mid-sweep -> err_count=0, confirming sel_q stays latched; start pulses while busy do not restart the sweep.
- rst asserted during pattern 10 -> next cycle shows a=b=0, busy=0, err_count=0, done=0; a subsequent start runs a full clean sweep.
- HOLD_CYCLES=1 instance, start held high -> patterns change every cycle; done pulses high for one cycle every 5th cycle; err_count is recomputed on each sweep.
